// File: rtl/tpu_pkg.sv
// Shared definitions for the matmul front end (mmu_loader / mmu_feeder).
// Contents:
//   state_t         loader sequencer state, 1-bit encoding {LOAD, COMPUTE}
//   OPERAND_BYTES   bytes per full operand load (4 weights + 4 inputs)
//   WEIGHT_BYTES    bytes of the load that are weights
//   *_DEF           default pass timing, shared with mmu_feeder's done window (2..5)
//   out_sel_f       result select for a given pass cycle index
package tpu_pkg;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  localparam int unsigned OPERAND_BYTES  = 8;
  localparam int unsigned WEIGHT_BYTES   = 4;

  localparam int unsigned CYCLE_W_DEF    = 4;
  localparam int unsigned LAST_CYCLE_DEF = 5;
  localparam int unsigned OUT_FIRST_DEF  = 2;

  // Results c00..c11 are presented in order over the feeder's done window;
  // outside that window the select parks at 0.
  function automatic logic [1:0] out_sel_f(input int unsigned cc,
                                           input int unsigned first,
                                           input int unsigned last);
    int unsigned diff;
    diff = cc - first;
    if ((cc >= first) && (cc <= last)) begin
      out_sel_f = diff[1:0];
    end else begin
      out_sel_f = 2'd0;
    end
  endfunction

endpackage

// File: rtl/mmu_loader_if.sv
// Host byte stream plus feeder-facing operand/control bundle of mmu_loader.
// Signals:
//   load_data/load_valid/load_ready  host byte stream (valid/ready)
//   keep_weights                     host request to reuse weights on the next load
//   weight0..3, input0..3            stored operands, to mmu_feeder
//   en, compute_cycles, output_sel   feeder controls
//   busy                             pass in progress
// Modports: master = host/consumer side, slave = mmu_loader.
interface mmu_loader_if #(
  parameter int unsigned CYCLE_W = tpu_pkg::CYCLE_W_DEF
);
  import tpu_pkg::*;

  logic [7:0]         load_data;
  logic               load_valid;
  logic               load_ready;
  logic               keep_weights;
  logic [7:0]         weight0;
  logic [7:0]         weight1;
  logic [7:0]         weight2;
  logic [7:0]         weight3;
  logic [7:0]         input0;
  logic [7:0]         input1;
  logic [7:0]         input2;
  logic [7:0]         input3;
  logic               en;
  logic [CYCLE_W-1:0] compute_cycles;
  logic [1:0]         output_sel;
  logic               busy;

  modport master (
    output load_data, load_valid, keep_weights,
    input  load_ready, weight0, weight1, weight2, weight3,
    input  input0, input1, input2, input3,
    input  en, compute_cycles, output_sel, busy
  );

  modport slave (
    input  load_data, load_valid, keep_weights,
    output load_ready, weight0, weight1, weight2, weight3,
    output input0, input1, input2, input3,
    output en, compute_cycles, output_sel, busy
  );

endinterface

// File: rtl/mmu_operand_regs.sv
// 8 x 8-bit operand register file: one write port, eight parallel read ports.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears all entries)
//   wr_en      write strobe
//   wr_addr    entry to write (0..3 weights, 4..7 inputs)
//   wr_data    byte to store, unmodified
//   rd_data    all entries, straight from the flops
module mmu_operand_regs
  import tpu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_addr,
  input  logic [7:0]                    wr_data,
  output logic [OPERAND_BYTES-1:0][7:0] rd_data
);

  logic [OPERAND_BYTES-1:0][7:0] mem_r;

  // Operand storage; entries only change on an explicit write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r <= '0;
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r;

endmodule

// File: rtl/mmu_loader.sv
// Operand store and pass sequencer upstream of mmu_feeder.
// Collects 8 host bytes (weight0..3 then input0..3), then runs one pass of
// LAST_CYCLE+1 cycles driving en/compute_cycles/output_sel. keep_weights,
// sampled in the last pass cycle, makes the next load carry inputs only.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts any pass)
//   bus  mmu_loader_if.slave: host byte stream, operands and feeder controls
module mmu_loader
  import tpu_pkg::*;
#(
  parameter int unsigned CYCLE_W    = CYCLE_W_DEF,
  parameter int unsigned LAST_CYCLE = LAST_CYCLE_DEF,
  parameter int unsigned OUT_FIRST  = OUT_FIRST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mmu_loader_if.slave  bus
);

  localparam logic [CYCLE_W-1:0] LAST_CC = CYCLE_W'(LAST_CYCLE);
  localparam logic [CYCLE_W-1:0] CC_ONE  = CYCLE_W'(1);

  state_t                        state_r, state_s;
  logic [2:0]                    ptr_r, ptr_s;
  logic [CYCLE_W-1:0]            cc_r, cc_s, cc_inc_s;
  logic [1:0]                    osel_r, osel_s;
  logic                          en_r, en_s;
  logic                          ready_r, ready_s;
  logic                          wr_en_s;
  logic [OPERAND_BYTES-1:0][7:0] ops_s;

  assign cc_inc_s = cc_r + CC_ONE;

  // Next-state, pointer, counter and output decode for the LOAD/COMPUTE sequencer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cc_s    = cc_r;
    osel_s  = osel_r;
    en_s    = en_r;
    ready_s = ready_r;
    wr_en_s = 1'b0;
    case (state_r)
      LOAD: begin
        if (bus.load_valid) begin
          wr_en_s = 1'b1;
          ptr_s   = ptr_r + 3'd1;
          if (ptr_r == 3'd7) begin
            // Last byte accepted: the pass starts on the very next cycle.
            state_s = COMPUTE;
            en_s    = 1'b1;
            ready_s = 1'b0;
            cc_s    = '0;
            osel_s  = 2'd0;
          end else begin
            state_s = LOAD;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      COMPUTE: begin
        if (cc_r == LAST_CC) begin
          state_s = LOAD;
          en_s    = 1'b0;
          ready_s = 1'b1;
          cc_s    = '0;
          osel_s  = 2'd0;
          // Inputs-only reload resumes at input0.
          ptr_s   = bus.keep_weights ? 3'd4 : 3'd0;
        end else begin
          cc_s    = cc_inc_s;
          // Select is derived from the next cc so both flops move together.
          osel_s  = out_sel_f(32'(cc_inc_s), OUT_FIRST, LAST_CYCLE);
        end
      end
      default: begin
        state_s = LOAD;
        ptr_s   = 3'd0;
        cc_s    = '0;
        osel_s  = 2'd0;
        en_s    = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered feeder controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD;
      ptr_r   <= 3'd0;
      cc_r    <= '0;
      osel_r  <= 2'd0;
      en_r    <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cc_r    <= cc_s;
      osel_r  <= osel_s;
      en_r    <= en_s;
      ready_r <= ready_s;
    end
  end

  mmu_operand_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (ptr_r),
    .wr_data (bus.load_data),
    .rd_data (ops_s)
  );

  assign bus.weight0        = ops_s[0];
  assign bus.weight1        = ops_s[1];
  assign bus.weight2        = ops_s[2];
  assign bus.weight3        = ops_s[3];
  assign bus.input0         = ops_s[WEIGHT_BYTES + 0];
  assign bus.input1         = ops_s[WEIGHT_BYTES + 1];
  assign bus.input2         = ops_s[WEIGHT_BYTES + 2];
  assign bus.input3         = ops_s[WEIGHT_BYTES + 3];
  assign bus.en             = en_r;
  assign bus.busy           = en_r;
  assign bus.compute_cycles = cc_r;
  assign bus.output_sel     = osel_r;
  assign bus.load_ready     = ready_r;

endmodule
